// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   - lsu_state_e   : FSM state encoding (idle, bus wait, response)
//   - F3*           : RV32I funct3 width codes for loads/stores
//   - TimeoutDefault: default bus wait budget in cycles
//   - funct3_legal(): whether a funct3 code is a valid load/store width
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } lsu_state_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam int unsigned TimeoutDefault = 16;

  // Stores have no unsigned variants, so only the three base widths are legal.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 inside {F3Byte, F3Half, F3Word};
    end
    return f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   i_funct3  - access width code (latched)
//   i_addr_lo - low two address bits (latched)
//   i_wdata   - raw store data (rs2)
//   i_rdata   - raw bus read word
//   o_be      - byte enables for the bus
//   o_wdata   - store data replicated across lanes
//   o_rdata   - load data extracted from its lane and extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane only looks at addr[1], so a misaligned halfword
  // (when not trapped) silently drops addr[0].
  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    unique case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    o_rdata = '0;
    unique case (i_funct3)
      F3Byte:  o_rdata = {{24{w_byte[7]}}, w_byte};
      F3Half:  o_rdata = {{16{w_half[15]}}, w_half};
      F3Word:  o_rdata = i_rdata;
      F3ByteU: o_rdata = {24'h0, w_byte};
      F3HalfU: o_rdata = {16'h0, w_half};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one core access, runs a single bus
// transaction with a timeout, then returns a one-cycle response.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (trap misaligned half/word
// accesses with an error and no bus transaction).
// Ports:
//   clk, reset                 - clock, async active-low reset
//   req_*                      - core request handshake and payload
//   rsp_valid/rsp_rdata/rsp_err- completion pulse, load data, error flag
//   bus_*                      - word-aligned bus master interface
//   busy                       - FSM not idle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  r_state, w_state_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [CntW-1:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [CntW-1:0] w_cnt_inc;
  logic        w_timeout;
  logic        w_misalign;
  logic        w_req_bad;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_be;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_bad = !funct3_legal(req_we, req_funct3) || w_misalign;
  assign w_cnt_inc = r_cnt + CntW'(1);
  // r_cnt counts unacknowledged bus cycles already spent; the cycle that
  // would make it TIMEOUT_CYCLES is the last one.
  assign w_timeout = (w_cnt_inc == CntW'(TIMEOUT_CYCLES));

  lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (bus_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_load_data)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_state_next = w_req_bad ? StResp : StBus;
        end
      end
      StBus: begin
        if (bus_ack || w_timeout) begin
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= w_req_bad;
          end
        end
        StBus: begin
          if (bus_ack) begin
            r_rdata <= r_we ? 32'h0 : w_load_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign bus_req   = (r_state == StBus);
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_wdata = w_wdata_rep;
  assign bus_be    = w_be;
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err & rsp_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit.
module tb_load_store_unit;

  localparam int unsigned Tmo = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // k: ack in bus cycle 1+k; k<0 means never ack.
  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic        exp_bus;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  last_bus;
    int  exp_lat;
    bit  got;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    bus_rdata  = v.rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    last_bus = (v.k < 0) ? Tmo : 1 + v.k;
    exp_lat  = !v.exp_bus ? 1 : ((v.k < 0) ? Tmo + 1 : 2 + v.k);
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (v.exp_bus && i <= last_bus) begin
        check({v.name, " bus_req"}, 32'(bus_req), 32'd1);
        check({v.name, " bus_we"}, 32'(bus_we), 32'(v.we));
        check({v.name, " bus_addr"}, bus_addr, v.exp_baddr);
        check({v.name, " bus_wdata"}, bus_wdata, v.exp_bwdata);
        check({v.name, " bus_be"}, 32'(bus_be), 32'(v.exp_be));
        check({v.name, " busy"}, 32'(busy), 32'd1);
      end else begin
        check({v.name, " bus_req low"}, 32'(bus_req), 32'd0);
      end
      bus_ack = v.exp_bus && (i == 1 + v.k);
      if (rsp_valid) begin
        got = 1'b1;
        check({v.name, " latency"}, 32'(i), 32'(exp_lat));
        check({v.name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({v.name, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
      end
    end
    bus_ack = 1'b0;
    if (!got) check({v.name, " rsp_valid seen"}, 32'd0, 32'd1);
    @(negedge clk);
    check({v.name, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
    check({v.name, " req_ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    //          name        we    f3      addr      wdata          rdata          k   bus  baddr
    //          bwdata         be       exp_rdata      err
    vecs[0]  = '{"lw",      1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 2,  1'b1, 32'h10,
                 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{"lb_neg",  1'b0, 3'b000, 32'h13, 32'h0,        32'h80123456, 0,  1'b1, 32'h10,
                 32'h0,        4'b1000, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{"lbu",     1'b0, 3'b100, 32'h13, 32'h0,        32'h80123456, 1,  1'b1, 32'h10,
                 32'h0,        4'b1000, 32'h00000080, 1'b0};
    vecs[3]  = '{"sh",      1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0,        0,  1'b1, 32'h20,
                 32'hABCDABCD, 4'b1100, 32'h0,        1'b0};
    vecs[4]  = '{"sb",      1'b1, 3'b000, 32'h01, 32'h123456A5, 32'hFFFFFFFF, 0,  1'b1, 32'h00,
                 32'hA5A5A5A5, 4'b0010, 32'h0,        1'b0};
    vecs[5]  = '{"lh_hi",   1'b0, 3'b001, 32'h02, 32'h0,        32'h80017FFF, 1,  1'b1, 32'h00,
                 32'h0,        4'b1100, 32'hFFFF8001, 1'b0};
    vecs[6]  = '{"lhu_lo",  1'b0, 3'b101, 32'h00, 32'h0,        32'h1234F00D, 0,  1'b1, 32'h00,
                 32'h0,        4'b0011, 32'h0000F00D, 1'b0};
    vecs[7]  = '{"sw",      1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        3,  1'b1, 32'h40,
                 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
    vecs[8]  = '{"ld_ill",  1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        0,  1'b0, 32'h0,
                 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[9]  = '{"st_ill",  1'b1, 3'b100, 32'h10, 32'h0,        32'h0,        0,  1'b0, 32'h0,
                 32'h0,        4'b0000, 32'h0,        1'b1};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[10] = '{"lw_mis",  1'b0, 3'b010, 32'h05, 32'h0,        32'h11223344, 0,  1'b0, 32'h0,
                 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[11] = '{"lh_mis",  1'b0, 3'b001, 32'h03, 32'h0,        32'hABCD0000, 0,  1'b0, 32'h0,
                 32'h0,        4'b0000, 32'h0,        1'b1};
`else
    vecs[10] = '{"lw_mis",  1'b0, 3'b010, 32'h05, 32'h0,        32'h11223344, 0,  1'b1, 32'h04,
                 32'h0,        4'b1111, 32'h11223344, 1'b0};
    vecs[11] = '{"lh_mis",  1'b0, 3'b001, 32'h03, 32'h0,        32'hABCD0000, 0,  1'b1, 32'h00,
                 32'h0,        4'b1100, 32'hFFFFABCD, 1'b0};
`endif
    vecs[12] = '{"timeout", 1'b0, 3'b010, 32'h80, 32'h0,        32'h55555555, -1, 1'b1, 32'h80,
                 32'h0,        4'b1111, 32'h0,        1'b1};
    vecs[13] = '{"lb_lane2",1'b0, 3'b000, 32'h12, 32'h0,        32'h007F0000, 0,  1'b1, 32'h10,
                 32'h0,        4'b0100, 32'h0000007F, 1'b0};

    // Reset state
    #3 reset = 1'b0;
    #1;
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);

    for (int v = 0; v < 14; v++) run_vec(vecs[v]);

    // bus_ack while idle must not start anything
    @(negedge clk);
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray ack busy", 32'(busy), 32'd0);
      check("stray ack rsp_valid", 32'(rsp_valid), 32'd0);
    end
    bus_ack = 1'b0;

    // Reset during BUS abandons the access
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid bus_req before", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    check("mid bus_req async", 32'(bus_req), 32'd0);
    check("mid busy", 32'(busy), 32'd0);
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("post rst req_ready", 32'(req_ready), 32'd1);
    end
    bus_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
